// File: rtl/parity_pkg.sv
// Shared types and constants for the parity_rx serial receiver.
package parity_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int ERR_CNT_W      = 8;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

endpackage

// File: rtl/parity_rx_if.sv
// Receiver-side bundle: serial line in, received word and status out.
interface parity_rx_if
  import parity_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) ();

  logic                 serial_in;
  logic [DATA_W-1:0]    data_out;
  logic                 data_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;
  logic [ERR_CNT_W-1:0] err_count;

  // master drives the line and consumes words; slave is the receiver itself
  modport master (
    output serial_in,
    input  data_out, data_valid, parity_err, frame_err, busy, err_count
  );

  modport slave (
    input  serial_in,
    output data_out, data_valid, parity_err, frame_err, busy, err_count
  );

endinterface

// File: rtl/parity_rx_sync_2ff.sv
// Two-flop synchronizer with a configurable reset value (sync_2ff).
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/parity_rx.sv
// Serial receiver for parity-protected frames: start, DATA_W bits LSB first, parity, stop.
// Optional saturating error counter enabled by defining PARITY_RX_ERR_CNT_EN.
module parity_rx
  import parity_pkg::*;
#(
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int CLKS_PER_BIT = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic        clock,
  input  logic        reset,
  parity_rx_if.slave  rx_if
);

  localparam int   TIMER_W = $clog2(CLKS_PER_BIT + 1);
  localparam int   IDX_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic ODD_BIT = 1'(PARITY_ODD);

  logic rx_s;

  sync_2ff #(.RESET_VAL(LINE_IDLE)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx_if.serial_in),
    .q     (rx_s)
  );

  rx_state_e         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              par_bit_q, par_bit_d;
  logic              wait_high_q, wait_high_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              busy_q, busy_d;
  logic              expire;

  assign expire = (timer_q == TIMER_W'(1));

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    par_bit_d   = par_bit_q;
    wait_high_d = wait_high_q;
    valid_d     = 1'b0;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    busy_d      = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        // after a frame error, a low line is not a new start bit until it has gone high
        if (wait_high_q) begin
          if (rx_s == LINE_IDLE) wait_high_d = 1'b0;
        end else if (rx_s == LINE_START) begin
          state_d = ST_START;
          timer_d = TIMER_W'(CLKS_PER_BIT / 2);
          busy_d  = 1'b1;
        end
      end
      ST_START: begin
        if (expire) begin
          if (rx_s == LINE_START) begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
            timer_d   = TIMER_W'(CLKS_PER_BIT);
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      ST_DATA: begin
        if (expire) begin
          shift_d = {rx_s, shift_q[DATA_W-1:1]};
          timer_d = TIMER_W'(CLKS_PER_BIT);
          if (bit_idx_q == IDX_W'(DATA_W - 1)) state_d = ST_PARITY;
          else                                 bit_idx_d = bit_idx_q + IDX_W'(1);
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      ST_PARITY: begin
        if (expire) begin
          par_bit_d = rx_s;
          state_d   = ST_STOP;
          timer_d   = TIMER_W'(CLKS_PER_BIT);
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      ST_STOP: begin
        if (expire) begin
          data_d      = shift_q;
          perr_d      = ((^shift_q) ^ par_bit_q) != ODD_BIT;
          ferr_d      = (rx_s != LINE_STOP);
          wait_high_d = (rx_s != LINE_IDLE);
          valid_d     = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      par_bit_q   <= 1'b0;
      wait_high_q <= 1'b0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      par_bit_q   <= par_bit_d;
      wait_high_q <= wait_high_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      busy_q      <= busy_d;
    end
  end

`ifdef PARITY_RX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // counts one per flagged frame, the cycle after the strobe
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (valid_q && (perr_q || ferr_q) && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign rx_if.err_count = err_cnt_q;
`else
  assign rx_if.err_count = '0;
`endif

  assign rx_if.data_out   = data_q;
  assign rx_if.data_valid = valid_q;
  assign rx_if.parity_err = perr_q;
  assign rx_if.frame_err  = ferr_q;
  assign rx_if.busy       = busy_q;

endmodule

// File: tb/tb_parity_rx.sv
// Directed bench for parity_rx: an even-parity and an odd-parity receiver share one line.
module tb_parity_rx;
  import parity_pkg::*;

  localparam int DATA_W = 16;
  localparam int CPB    = 8;
  localparam int LAT    = 2 + CPB / 2 + (DATA_W + 2) * CPB + 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic lineLevel = 1'b1;

  int testsRun    = 0;
  int testsFailed = 0;
  int cycleCount  = 0;
  int validCount  = 0;
  int lastValidCycle = 0;
  logic [DATA_W-1:0] capData = '0;
  logic capPerr = 1'b0, capFerr = 1'b0, capBusy = 1'b0, capOddPerr = 1'b0, capOddValid = 1'b0;
  int expErrCount = 0;

  parity_rx_if #(.DATA_W(DATA_W)) evenIf ();
  parity_rx_if #(.DATA_W(DATA_W)) oddIf ();

  assign evenIf.serial_in = lineLevel;
  assign oddIf.serial_in  = lineLevel;

  parity_rx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dutEven (
    .clock (clock),
    .reset (reset),
    .rx_if (evenIf.slave)
  );

  parity_rx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB), .PARITY_ODD(1)) dutOdd (
    .clock (clock),
    .reset (reset),
    .rx_if (oddIf.slave)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycleCount <= cycleCount + 1;

  // capture what the receivers present on each strobe
  always @(negedge clock) begin
    if (evenIf.data_valid) begin
      validCount     = validCount + 1;
      lastValidCycle = cycleCount;
      capData        = evenIf.data_out;
      capPerr        = evenIf.parity_err;
      capFerr        = evenIf.frame_err;
      capBusy        = evenIf.busy;
      capOddPerr     = oddIf.parity_err;
      capOddValid    = oddIf.data_valid;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic holdBit(input logic b);
    lineLevel = b;
    repeat (CPB) @(negedge clock);
  endtask

  // drives one full frame from a negedge and checks the strobe it produces
  task automatic applyStimulus(input string tag, input logic [DATA_W-1:0] data, input logic par,
                               input logic stopBit, input logic expPerrEven, input logic expPerrOdd,
                               input logic expFerr);
    int startCycle;
    int validBefore;
    validBefore = validCount;
    startCycle  = cycleCount;
    holdBit(LINE_START);
    for (int i = 0; i < DATA_W; i++) holdBit(data[i]);
    holdBit(par);
    holdBit(stopBit);
    checkOutput({tag, "_strobes"}, 32'(validCount - validBefore), 32'd1);
    checkOutput({tag, "_latency"}, 32'(lastValidCycle - startCycle), 32'(LAT));
    checkOutput({tag, "_data"}, 32'(capData), 32'(data));
    checkOutput({tag, "_perr"}, 32'(capPerr), 32'(expPerrEven));
    checkOutput({tag, "_ferr"}, 32'(capFerr), 32'(expFerr));
    checkOutput({tag, "_busy_at_valid"}, 32'(capBusy), 32'd0);
    checkOutput({tag, "_odd_valid"}, 32'(capOddValid), 32'd1);
    checkOutput({tag, "_odd_perr"}, 32'(capOddPerr), 32'(expPerrOdd));
`ifdef PARITY_RX_ERR_CNT_EN
    if ((expPerrEven || expFerr) && expErrCount < 255) expErrCount++;
`endif
    checkOutput({tag, "_err_count"}, 32'(evenIf.err_count), 32'(expErrCount));
  endtask

  initial begin
    int vb;
    // reset state
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("rst_data", 32'(evenIf.data_out), 32'h0);
    checkOutput("rst_valid", 32'(evenIf.data_valid), 32'd0);
    checkOutput("rst_perr", 32'(evenIf.parity_err), 32'd0);
    checkOutput("rst_ferr", 32'(evenIf.frame_err), 32'd0);
    checkOutput("rst_busy", 32'(evenIf.busy), 32'd0);
    checkOutput("rst_errcnt", 32'(evenIf.err_count), 32'd0);
    repeat (3) @(negedge clock);

    // clean frame: 0xA5C3 has eight ones, parity bit 0
    applyStimulus("a5c3", 16'hA5C3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    // back-to-back: 0x0001 with parity 0 is wrong for even, right for odd
    applyStimulus("x0001", 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    // 0x1234 has five ones; parity 1 is good for even, stop bit low
    applyStimulus("x1234", 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    // line stays low after the bad stop bit: no new frame may start
    vb = validCount;
    repeat (3 * CPB) @(negedge clock);
    checkOutput("ferr_hold_busy", 32'(evenIf.busy), 32'd0);
    checkOutput("ferr_hold_data", 32'(evenIf.data_out), 32'h1234);
    lineLevel = LINE_IDLE;
    repeat (2 * CPB) @(negedge clock);
    checkOutput("ferr_hold_nostrobe", 32'(validCount - vb), 32'd0);
    applyStimulus("after_ferr", 16'h00F0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    // two-cycle glitch: start detected, then rejected
    repeat (CPB) @(negedge clock);
    vb = validCount;
    lineLevel = LINE_START;
    repeat (2) @(negedge clock);
    lineLevel = LINE_IDLE;
    @(negedge clock);
    checkOutput("glitch_busy_rise", 32'(evenIf.busy), 32'd1);
    repeat (CPB) @(negedge clock);
    checkOutput("glitch_busy_fall", 32'(evenIf.busy), 32'd0);
    repeat (2 * CPB) @(negedge clock);
    checkOutput("glitch_nostrobe", 32'(validCount - vb), 32'd0);

    // reset in the middle of data bit 7
    vb = validCount;
    holdBit(LINE_START);
    for (int i = 0; i < 7; i++) holdBit(1'b1);
    lineLevel = 1'b0;
    repeat (CPB / 2) @(negedge clock);
    lineLevel = LINE_IDLE;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    expErrCount = 0;
    checkOutput("midrst_data", 32'(evenIf.data_out), 32'h0);
    checkOutput("midrst_busy", 32'(evenIf.busy), 32'd0);
    checkOutput("midrst_ferr", 32'(evenIf.frame_err), 32'd0);
    checkOutput("midrst_errcnt", 32'(evenIf.err_count), 32'd0);
    repeat (3 * CPB) @(negedge clock);
    checkOutput("midrst_nostrobe", 32'(validCount - vb), 32'd0);
    applyStimulus("xffff", 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

`ifdef PARITY_RX_ERR_CNT_EN
    // saturation: 260 bad-parity frames
    vb = validCount;
    for (int n = 0; n < 260; n++) begin
      holdBit(LINE_START);
      for (int i = 0; i < DATA_W; i++) holdBit(i == 0);
      holdBit(1'b0);
      holdBit(1'b1);
    end
    repeat (2) @(negedge clock);
    checkOutput("sat_strobes", 32'(validCount - vb), 32'd260);
    checkOutput("sat_errcnt", 32'(evenIf.err_count), 32'd255);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("sat_rst_errcnt", 32'(evenIf.err_count), 32'd0);
`else
    checkOutput("errcnt_tied", 32'(evenIf.err_count), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
